pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Consumes the branch/halt/PCS control outputs of the opcode decoder and owns architectural PC and N/Z/V flag state for the single-cycle 16-bit core.
- Computes next PC for sequential, B (PC-relative, conditional) and BR (register, conditional) instructions.
- Supplies PC+2 for PCS writeback and raises a sticky halted indication on HLT.
- Sits between instruction memory address port and the decoder/ALU.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
IMM_W, 9, width of signed branch offset field (instruction bits [8:0])

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
inst_valid  input  1  fetched instruction at pc is valid this cycle
stall  input  1  hold all state this cycle (no commit)
halt  input  1  decoded HLT
BEn  input  1  decoded branch (B or BR)
Br  input  1  branch target from register (BR) when 1, PC-relative (B) when 0
ccc  input  3  condition code, instruction bits [11:9]
imm  input  IMM_W  signed word offset, instruction bits [8:0]
rs_data  input  16  register operand for BR target
flag_en  input  3  per-flag write enables {N,Z,V} from executing instruction
alu_n, alu_z, alu_v  input  1 each  ALU flag results
pc  output  16  current instruction address
pc_plus2  output  16  pc + 2, for PCS writeback
branch_taken  output  1  combinational: branch resolves taken this cycle
halted  output  1  sticky, processor halted
flags  output  3  registered {N,Z,V}

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, flags=3'b000, state=RUN, halted=0. Outputs valid immediately while reset is held.
- FSM states: RUN, HALT.
  - HALT is entered only from RUN, on commit of halt.
  - HALT exits only through reset.
- commit = (state==RUN) & inst_valid & ~stall. No register changes when commit=0.
- Next PC on commit:
  - halt=1: pc holds (stays on HLT address); state moves to HALT next edge; halted=1 from that edge.
  - BEn=1 and cond true, Br=0: pc <= pc_plus2 + (sign_extend(imm) << 1), 16-bit wrap-around, no overflow detection.
  - BEn=1 and cond true, Br=1: pc <= rs_data; bit 0 passed through unmodified.
  - Otherwise: pc <= pc_plus2. Wraps 16'hFFFE -> 16'h0000.
- Branch condition uses registered flags (pre-update values) only:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- branch_taken = commit & BEn & cond. Forced 0 in HALT.
- Flags: on commit, each flag bit updates iff its flag_en bit is set; other bits hold.
  - Same-cycle update and branch read: the branch sees old flags; the new value is visible the next cycle.
- halt together with BEn: halt has priority; no branch.
- pc_plus2 = pc + 2, combinational, 16-bit.
- Reset asserted mid-HALT or mid-stall: returns to RUN at RESET_PC; flags cleared.
- Latency: next-PC decision is combinational within the cycle; pc updates at the next rising edge.

Decomposition:
- Shared package (cpu_pkg): condition-code localparams (CC_NE..CC_UNC), flag bit indices (FLAG_N=2, FLAG_Z=1, FLAG_V=0), FSM state encoding, RESET_PC default.
- One sub-module: branch_cond_eval. Pure combinational: ccc + flags -> cond.
- 16-bit adders stay in pc_sequencer.

Test Plan:
- Reset then 4 commits of plain instructions (BEn=0) -> pc 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; pc_plus2 tracks pc+2.
- Flags Z=1 (flag_en=3'b010, alu_z=1) on the instruction at pc=0x0010; then B ccc=001 imm=9'h1FE (-2) at pc=0x0012 -> branch_taken=1, pc=0x0010. Same B with Z=0 -> pc=0x0014.
- BR ccc=111, rs_data=0x1234, pc=0x0040 -> pc=0x1234 next edge. Same with ccc=110 and V=0 -> pc=0x0042.
- Flag-write and branch in the same cycle: flags=000, flag_en=3'b010 with alu_z=1, B ccc=001 -> not taken, pc+2; flags read 3'b010 next cycle.
- HLT at pc=0x0020 -> pc holds 0x0020, halted=1 after one edge; later BEn/inst_valid pulses are ignored; rst_n low -> pc=0x0000, halted=0 asynchronously.
- stall=1 or inst_valid=0 for 3 cycles during a taken B -> pc and flags unchanged, branch_taken=0; commits on the first cycle with stall=0. Wrap check: pc=0xFFFE plain commit -> 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: condition codes,
// flag bit positions, sequencer FSM encoding and reset default.
package cpu_pkg;

    localparam logic [2:0] CC_NE  = 3'd0;
    localparam logic [2:0] CC_EQ  = 3'd1;
    localparam logic [2:0] CC_GT  = 3'd2;
    localparam logic [2:0] CC_LT  = 3'd3;
    localparam logic [2:0] CC_GE  = 3'd4;
    localparam logic [2:0] CC_LE  = 3'd5;
    localparam logic [2:0] CC_OV  = 3'd6;
    localparam logic [2:0] CC_UNC = 3'd7;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/ALU control bundle into the sequencer and
// PC/flag state back out to fetch and writeback.
interface pc_sequencer_if #(
    parameter int IMM_W = 9
);
    logic             inst_valid;
    logic             stall;
    logic             halt;
    logic             BEn;
    logic             Br;
    logic [2:0]       ccc;
    logic [IMM_W-1:0] imm;
    logic [15:0]      rs_data;
    logic [2:0]       flag_en;
    logic             alu_n;
    logic             alu_z;
    logic             alu_v;
    logic [15:0]      pc;
    logic [15:0]      pc_plus2;
    logic             branch_taken;
    logic             halted;
    logic [2:0]       flags;

    modport master (
        output inst_valid, stall, halt, BEn, Br,
        output ccc, imm, rs_data, flag_en,
        output alu_n, alu_z, alu_v,
        input  pc, pc_plus2, branch_taken,
        input  halted, flags
    );

    modport slave (
        input  inst_valid, stall, halt, BEn, Br,
        input  ccc, imm, rs_data, flag_en,
        input  alu_n, alu_z, alu_v,
        output pc, pc_plus2, branch_taken,
        output halted, flags
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Branch condition evaluation from a condition code and
// the registered {N,Z,V} flags.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond
);
    logic n;
    logic z;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        cond = 1'b0;
        unique case (1'b1)
            (ccc == CC_NE): cond = ~z;
            (ccc == CC_EQ): cond = z;
            (ccc == CC_GT): cond = ~z & ~n;
            (ccc == CC_LT): cond = n;
            (ccc == CC_GE): cond = z | ~n;
            (ccc == CC_LE): cond = n | z;
            (ccc == CC_OV): cond = v;
            default:        cond = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC and flag owner: sequential, PC-relative
// and register branches, PCS link value and sticky halt.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEF,
    parameter int          IMM_W    = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  sif
);
    seq_state_t  state;
    logic [15:0] pc_q;
    logic [2:0]  flags_q;
    logic        halted_q;
    logic [15:0] pc_plus2;
    logic [15:0] sext;
    logic [15:0] rel_target;
    logic [15:0] pc_nxt;
    logic        commit;
    logic        cond;
    logic        take;

    branch_cond_eval u_cond (
        .ccc   (sif.ccc),
        .flags (flags_q),
        .cond  (cond)
    );

    assign commit = (state == ST_RUN) & sif.inst_valid & ~sif.stall;
    // halt wins over a same-cycle branch
    assign take = commit & sif.BEn & cond & ~sif.halt;

    assign pc_plus2   = pc_q + 16'd2;
    assign sext       = {{(16-IMM_W){sif.imm[IMM_W-1]}}, sif.imm};
    assign rel_target = pc_plus2 + {sext[14:0], 1'b0};

    always_comb begin
        pc_nxt = pc_plus2;
        if (sif.halt)
            pc_nxt = pc_q;
        else if (take)
            pc_nxt = sif.Br ? sif.rs_data : rel_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pc_q     <= RESET_PC;
            flags_q  <= 3'b000;
            halted_q <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (commit) begin
                        pc_q <= pc_nxt;
                        if (sif.flag_en[FLAG_N])
                            flags_q[FLAG_N] <= sif.alu_n;
                        if (sif.flag_en[FLAG_Z])
                            flags_q[FLAG_Z] <= sif.alu_z;
                        if (sif.flag_en[FLAG_V])
                            flags_q[FLAG_V] <= sif.alu_v;
                        if (sif.halt) begin
                            state    <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign sif.pc           = pc_q;
    assign sif.pc_plus2     = pc_plus2;
    assign sif.branch_taken = take;
    assign sif.halted       = halted_q;
    assign sif.flags        = flags_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed program steps
// followed by randomized traffic against a behavioural model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.IMM_W(9)) sif ();

    pc_sequencer #(.RESET_PC(16'h0000), .IMM_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] pc2;
        logic [2:0]  flags;
        logic        halted;
        logic        bt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    logic [2:0]  m_flags;
    logic        m_halted;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic logic cond_f(input logic [2:0] cc,
                                    input logic [2:0] f);
        logic n;
        logic z;
        logic v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Drive one cycle's inputs, record expected outputs, advance model
    task automatic step(input logic v, input logic st, input logic h,
                        input logic ben, input logic br,
                        input logic [2:0] cc, input logic [8:0] im,
                        input logic [15:0] rs, input logic [2:0] fen,
                        input logic n, input logic z, input logic vv);
        exp_t e;
        logic c;
        logic bt;
        int tgt;
        sif.inst_valid = v;
        sif.stall = st;
        sif.halt = h;
        sif.BEn = ben;
        sif.Br = br;
        sif.ccc = cc;
        sif.imm = im;
        sif.rs_data = rs;
        sif.flag_en = fen;
        sif.alu_n = n;
        sif.alu_z = z;
        sif.alu_v = vv;
        c = !m_halted && v && !st;
        bt = c && ben && !h && cond_f(cc, m_flags);
        e.pc = m_pc;
        e.pc2 = 16'(int'(m_pc) + 2);
        e.flags = m_flags;
        e.halted = m_halted;
        e.bt = bt;
        exp_q.push_back(e);
        if (c) begin
            if (h) begin
                m_halted = 1'b1;
            end else if (bt && br) begin
                m_pc = rs;
            end else if (bt) begin
                tgt = int'(m_pc) + 2 + 2 * int'($signed(im));
                m_pc = 16'(tgt);
            end else begin
                m_pc = 16'(int'(m_pc) + 2);
            end
            if (fen[2]) m_flags[2] = n;
            if (fen[1]) m_flags[1] = z;
            if (fen[0]) m_flags[0] = vv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic plain();
        step(1, 0, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'b000, 0, 0, 0);
    endtask

    task automatic jump(input logic [15:0] t);
        step(1, 0, 0, 1, 1, 3'd7, 9'd0, t, 3'b000, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pc", sif.pc, 16'h0000);
        chk("rst_halted", {15'd0, sif.halted}, 16'd0);
        chk("rst_flags", {13'd0, sif.flags}, 16'd0);
        m_pc = 16'h0000;
        m_flags = 3'b000;
        m_halted = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", sif.pc, e.pc);
            chk("pc_plus2", sif.pc_plus2, e.pc2);
            chk("flags", {13'd0, sif.flags}, {13'd0, e.flags});
            chk("halted", {15'd0, sif.halted}, {15'd0, e.halted});
            chk("branch_taken", {15'd0, sif.branch_taken},
                {15'd0, e.bt});
        end
    end

    initial begin
        sif.inst_valid = 0;
        sif.stall = 0;
        sif.halt = 0;
        sif.BEn = 0;
        sif.Br = 0;
        sif.ccc = 0;
        sif.imm = 0;
        sif.rs_data = 0;
        sif.flag_en = 0;
        sif.alu_n = 0;
        sif.alu_z = 0;
        sif.alu_v = 0;
        m_pc = 0;
        m_flags = 0;
        m_halted = 0;
        #2;
        do_reset();

        repeat (5) plain();

        jump(16'h0010);
        step(1, 0, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'b010, 0, 1, 0);
        step(1, 0, 0, 1, 0, 3'd1, 9'h1FE, 16'h0, 3'b000, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'b010, 0, 0, 0);
        step(1, 0, 0, 1, 0, 3'd1, 9'h1FE, 16'h0, 3'b000, 0, 0, 0);

        jump(16'h0040);
        step(1, 0, 0, 1, 1, 3'd7, 9'd0, 16'h1234, 3'b000, 0, 0, 0);
        jump(16'h0040);
        step(1, 0, 0, 1, 1, 3'd6, 9'd0, 16'h1234, 3'b000, 0, 0, 0);

        step(1, 0, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'b111, 0, 0, 0);
        step(1, 0, 0, 1, 0, 3'd1, 9'h010, 16'h0, 3'b010, 0, 1, 0);
        plain();

        step(1, 1, 0, 1, 0, 3'd7, 9'h020, 16'h0, 3'b111, 1, 1, 1);
        step(0, 0, 0, 1, 0, 3'd7, 9'h020, 16'h0, 3'b111, 1, 1, 1);
        step(1, 1, 0, 1, 0, 3'd7, 9'h020, 16'h0, 3'b111, 1, 1, 1);
        step(1, 0, 0, 1, 0, 3'd7, 9'h020, 16'h0, 3'b000, 0, 0, 0);

        jump(16'hFFFE);
        plain();
        plain();

        jump(16'h0020);
        step(1, 0, 1, 1, 0, 3'd7, 9'h040, 16'h0, 3'b000, 0, 0, 0);
        jump(16'h0300);
        step(1, 0, 0, 0, 0, 3'd0, 9'd0, 16'h0, 3'b111, 1, 1, 1);
        plain();
        do_reset();
        plain();

        for (int i = 0; i < 400; i++) begin
            logic h;
            h = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                 h, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 3'($urandom), 9'($urandom), 16'($urandom),
                 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (m_halted && $urandom_range(0, 3) == 0) begin
                do_reset();
            end
        end

        @(posedge clk);
        #1;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
